staircase_sequencer: RTL



---
 rtl/staircase_pkg.sv | 21 ++
 rtl/staircase_step_calc.sv | 35 +++
 rtl/staircase_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/staircase_pkg.sv
// Shared types and constants for the staircase waveform sequencer.
// Imported by the step calculator and the sequencer top.
package staircase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_THERM = 1'b0;
    localparam logic MODE_LIN   = 1'b1;

    localparam logic SHAPE_SAW  = 1'b0;
    localparam logic SHAPE_TRI  = 1'b1;

    localparam logic DIR_UP     = 1'b0;
    localparam logic DIR_DOWN   = 1'b1;

endpackage

// File: rtl/staircase_step_calc.sv
// Combinational next-code generator for thermometer or linear steps.
// at_top flags the current code; at_bottom flags a stepped code of 0.
module staircase_step_calc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] val,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] next,
    output logic             at_top,
    output logic             at_bottom
);
    import staircase_pkg::*;

    localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};

    // Pick the neighbouring code in the requested direction
    always_comb begin
        next = val;
        unique case (1'b1)
            (dir == DIR_UP) && (mode == MODE_THERM):
                next = {val[WIDTH-2:0], 1'b1};
            (dir == DIR_UP) && (mode == MODE_LIN):
                next = val + 1'b1;
            (dir == DIR_DOWN) && (mode == MODE_THERM):
                next = val >> 1;
            default:
                next = val - 1'b1;
        endcase
    end

    assign at_top    = (val == TOP);
    assign at_bottom = (next == '0);

endmodule

// File: rtl/staircase_sequencer.sv
// Staircase waveform controller: dwell timer, period counter and FSM.
// Steps are throttled by dac_ready so a slow DAC never misses a code.
module staircase_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 8,
    parameter int CYC_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_mode,
    input  logic               cfg_tri,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [CYC_W-1:0]   cfg_cycles,
    input  logic               dac_ready,
    output logic [WIDTH-1:0]   val,
    output logic               val_valid,
    output logic               busy,
    output logic               done
);
    import staircase_pkg::*;

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [CYC_W-1:0]   per_cnt;

    logic               mode_q;
    logic               tri_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [CYC_W-1:0]   cycles_q;

    logic               dir;
    logic [WIDTH-1:0]   calc_next;
    logic               at_top;
    logic               at_bottom;

    logic               saw_wrap;
    logic [WIDTH-1:0]   step_val;
    logic               period_end;
    logic               last_period;
    state_t             adv_state;

    // Triangle turns around at the top; descending continues until 0
    assign dir = (state == DOWN) || ((tri_q == SHAPE_TRI) && at_top);

    staircase_step_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .val       (val),
        .mode      (mode_q),
        .dir       (dir),
        .next      (calc_next),
        .at_top    (at_top),
        .at_bottom (at_bottom)
    );

    // Resolve the code, period flags and shape state for an advance
    always_comb begin
        saw_wrap    = (state == UP) && at_top && (tri_q == SHAPE_SAW);
        step_val    = saw_wrap ? '0 : calc_next;
        period_end  = saw_wrap || at_bottom;
        last_period = (cycles_q != '0) &&
                      (CYC_W'(per_cnt + 1'b1) == cycles_q);
        adv_state   = state;
        if (period_end)
            adv_state = UP;
        else if (dir == DIR_DOWN)
            adv_state = DOWN;
        else
            adv_state = UP;
    end

    // Main FSM with registered outputs, counters and config capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            val       <= '0;
            val_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            per_cnt   <= '0;
            mode_q    <= MODE_THERM;
            tri_q     <= SHAPE_SAW;
            dwell_q   <= '0;
            cycles_q  <= '0;
        end else begin
            val_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state     <= UP;
                        val       <= '0;
                        val_valid <= 1'b1;
                        busy      <= 1'b1;
                        dwell_cnt <= cfg_dwell;
                        per_cnt   <= '0;
                        mode_q    <= cfg_mode;
                        tri_q     <= cfg_tri;
                        dwell_q   <= cfg_dwell;
                        cycles_q  <= cfg_cycles;
                    end
                end
                UP, DOWN: begin
                    if (stop) begin
                        state     <= IDLE;
                        val       <= '0;
                        val_valid <= 1'b1;
                        busy      <= 1'b0;
                        dwell_cnt <= '0;
                        per_cnt   <= '0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (dac_ready) begin
                        val       <= step_val;
                        val_valid <= 1'b1;
                        if (period_end && last_period) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            dwell_cnt <= '0;
                            per_cnt   <= '0;
                        end else begin
                            state     <= adv_state;
                            dwell_cnt <= dwell_q;
                            if (period_end && (per_cnt != '1))
                                per_cnt <= per_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    val   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
